// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, register constants,
// ALU op encodings and the EX-stage control bundle.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AOPW = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [AOPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [AOPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [AOPW-1:0] ALU_AND  = 4'd2;
  localparam logic [AOPW-1:0] ALU_OR   = 4'd3;
  localparam logic [AOPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [AOPW-1:0] ALU_SLL  = 4'd5;
  localparam logic [AOPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [AOPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [AOPW-1:0] ALU_SLT  = 4'd8;
  localparam logic [AOPW-1:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            alu_src;
    logic [AOPW-1:0] alu_op;
  } ex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check: a load in EX whose destination
// is read by the instruction currently in ID.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use_stall
);
  import riscv_pkg::*;

  logic hit1;
  logic hit2;

  assign hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_uses_rs2 && (id_rs2 == ex_rd);

  assign load_use_stall = ex_valid && ex_mem_rd &&
                          (ex_rd != REG_ZERO) &&
                          id_valid && (hit1 || hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass,
// load-use bubble insertion and branch flush.
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AOPW = riscv_pkg::AOPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_reg_wr,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            id_alu_src,
  input  logic [AOPW-1:0] id_alu_op,
  input  logic            wb_reg_wr,
  input  logic [4:0]      wb_wr_reg,
  input  logic [XLEN-1:0] wb_wr_data,
  input  logic            ex_flush,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_wr,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_alu_src,
  output logic [AOPW-1:0] ex_alu_op
);
  import riscv_pkg::*;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  ex_ctrl_t        ctrl_d;
  ex_ctrl_t        ctrl_q;
  logic            bubble;

  load_use_detect u_lud (
    .ex_valid       (ex_valid),
    .ex_mem_rd      (ctrl_q.mem_rd),
    .ex_rd          (ex_rd),
    .id_valid       (id_valid),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .load_use_stall (load_use_stall)
  );

  // x0 is forced to zero even though the regfile stores it
  always_comb begin
    op1 = id_rs1_data;
    if (id_rs1 == REG_ZERO)
      op1 = '0;
    else if (wb_reg_wr && wb_wr_reg == id_rs1)
      op1 = wb_wr_data;
  end

  always_comb begin
    op2 = id_rs2_data;
    if (id_rs2 == REG_ZERO)
      op2 = '0;
    else if (wb_reg_wr && wb_wr_reg == id_rs2)
      op2 = wb_wr_data;
  end

  always_comb begin
    ctrl_d.reg_wr  = id_reg_wr  && id_valid;
    ctrl_d.mem_rd  = id_mem_rd  && id_valid;
    ctrl_d.mem_wr  = id_mem_wr  && id_valid;
    ctrl_d.alu_src = id_alu_src && id_valid;
    ctrl_d.alu_op  = id_valid ? id_alu_op : '0;
  end

  assign bubble = ex_flush || load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ctrl_q      <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ctrl_q      <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= op1;
      ex_rs2_data <= op2;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ctrl_q      <= ctrl_d;
    end
  end

  assign ex_reg_wr  = ctrl_q.reg_wr;
  assign ex_mem_rd  = ctrl_q.mem_rd;
  assign ex_mem_wr  = ctrl_q.mem_wr;
  assign ex_alu_src = ctrl_q.alu_src;
  assign ex_alu_op  = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, bypass,
// load-use bubble, flush and asynchronous reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_wr, id_mem_rd, id_mem_wr, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        wb_reg_wr;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_wr_data;
  logic        ex_flush;
  logic        load_use_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src;
  logic [3:0]  ex_alu_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op),
    .wb_reg_wr(wb_reg_wr), .wb_wr_reg(wb_wr_reg),
    .wb_wr_data(wb_wr_data),
    .ex_flush(ex_flush),
    .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op)
  );

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_reg_wr = 0; id_mem_rd = 0; id_mem_wr = 0;
    id_alu_src = 0; id_alu_op = 0;
    wb_reg_wr = 0; wb_wr_reg = 0; wb_wr_data = 0;
    ex_flush = 0;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // puts "lw x7" (rd=rd_v) into EX
  task automatic load_lw(input logic [4:0] rd_v);
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h200; id_rd = rd_v;
    id_rs1 = 5'd2; id_uses_rs1 = 1; id_rs1_data = 32'h1000;
    id_reg_wr = 1; id_mem_rd = 1; id_alu_src = 1;
    edge_sample();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ex_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %0b want 0", ex_valid);
    end
    tests++;
    if (ex_pc !== 32'h0) begin
      fails++; $display("FAIL reset_pc got %h want 0", ex_pc);
    end
    tests++;
    if (ex_reg_wr !== 1'b0) begin
      fails++; $display("FAIL reset_reg_wr got %0b want 0", ex_reg_wr);
    end
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall got %0b want 0", load_use_stall);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_capture();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h100;
    id_rs1 = 5; id_rs1_data = 32'h11; id_uses_rs1 = 1;
    id_rs2 = 6; id_rs2_data = 32'h22; id_uses_rs2 = 1;
    id_rd = 9; id_imm = 32'h8;
    id_reg_wr = 1; id_alu_src = 1; id_alu_op = 4'd3;
    edge_sample();
    tests++;
    if (ex_valid !== 1'b1) begin
      fails++; $display("FAIL cap_valid got %0b want 1", ex_valid);
    end
    tests++;
    if (ex_pc !== 32'h100) begin
      fails++; $display("FAIL cap_pc got %h want 100", ex_pc);
    end
    tests++;
    if (ex_rs1_data !== 32'h11) begin
      fails++; $display("FAIL cap_rs1d got %h want 11", ex_rs1_data);
    end
    tests++;
    if (ex_rs2_data !== 32'h22) begin
      fails++; $display("FAIL cap_rs2d got %h want 22", ex_rs2_data);
    end
    tests++;
    if (ex_imm !== 32'h8) begin
      fails++; $display("FAIL cap_imm got %h want 8", ex_imm);
    end
    tests++;
    if ({ex_rs1, ex_rs2, ex_rd} !== {5'd5, 5'd6, 5'd9}) begin
      fails++; $display("FAIL cap_regs got %0d %0d %0d want 5 6 9",
                        ex_rs1, ex_rs2, ex_rd);
    end
    tests++;
    if ({ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, ex_alu_op}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd3}) begin
      fails++; $display("FAIL cap_ctrl got %b%b%b%b %h want 1001 3",
        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, ex_alu_op);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h11;
    id_rs2 = 6; id_rs2_data = 32'h22;
    wb_reg_wr = 1; wb_wr_reg = 5; wb_wr_data = 32'hDEAD;
    edge_sample();
    tests++;
    if (ex_rs1_data !== 32'hDEAD) begin
      fails++; $display("FAIL byp_rs1 got %h want dead", ex_rs1_data);
    end
    tests++;
    if (ex_rs2_data !== 32'h22) begin
      fails++; $display("FAIL byp_rs2_nohit got %h want 22", ex_rs2_data);
    end
    @(negedge clk);
    wb_wr_reg = 6; wb_wr_data = 32'hBEEF;
    edge_sample();
    tests++;
    if (ex_rs2_data !== 32'hBEEF) begin
      fails++; $display("FAIL byp_rs2 got %h want beef", ex_rs2_data);
    end
    tests++;
    if (ex_rs1_data !== 32'h11) begin
      fails++; $display("FAIL byp_rs1_nohit got %h want 11", ex_rs1_data);
    end
    @(negedge clk);
    wb_wr_reg = 0; id_rs1 = 0; id_rs1_data = 32'h11;
    edge_sample();
    tests++;
    if (ex_rs1_data !== 32'h0) begin
      fails++; $display("FAIL byp_x0 got %h want 0", ex_rs1_data);
    end
    @(negedge clk);
    wb_reg_wr = 0; wb_wr_reg = 5;
    id_rs1 = 5; id_rs1_data = 32'h77;
    edge_sample();
    tests++;
    if (ex_rs1_data !== 32'h77) begin
      fails++; $display("FAIL byp_wr_off got %h want 77", ex_rs1_data);
    end
    // invalid slot must not carry control bits
    @(negedge clk);
    idle_inputs();
    id_valid = 0; id_reg_wr = 1; id_mem_wr = 1; id_alu_op = 4'd5;
    edge_sample();
    tests++;
    if ({ex_valid, ex_reg_wr, ex_mem_wr, ex_alu_op} !== 7'b0) begin
      fails++; $display("FAIL gate_invalid got %b%b%b %h want 000 0",
        ex_valid, ex_reg_wr, ex_mem_wr, ex_alu_op);
    end
  endtask

  task automatic test_load_use();
    load_lw(5'd7);
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h204; id_rd = 8;
    id_rs1 = 3; id_uses_rs1 = 1; id_rs1_data = 32'h33;
    id_rs2 = 7; id_uses_rs2 = 1; id_rs2_data = 32'h44;
    id_reg_wr = 1;
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin
      fails++; $display("FAIL lu_stall got %0b want 1", load_use_stall);
    end
    edge_sample();
    tests++;
    if ({ex_valid, ex_reg_wr, ex_mem_rd, ex_rd} !== 8'b0) begin
      fails++; $display("FAIL lu_bubble got v=%0b wr=%0b rd=%0d want 0",
        ex_valid, ex_reg_wr, ex_rd);
    end
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_stall_drop got %0b want 0", load_use_stall);
    end
    edge_sample();
    tests++;
    if ({ex_valid, ex_pc, ex_rs2, ex_rs2_data} !==
        {1'b1, 32'h204, 5'd7, 32'h44}) begin
      fails++; $display("FAIL lu_recap got v=%0b pc=%h rs2=%0d d=%h want 1 204 7 44",
        ex_valid, ex_pc, ex_rs2, ex_rs2_data);
    end
    load_lw(5'd7);
    @(negedge clk);
    id_uses_rs2 = 0;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_unused got %0b want 0", load_use_stall);
    end
    load_lw(5'd0);
    @(negedge clk);
    id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_x0 got %0b want 0", load_use_stall);
    end
    // a non-load producer never stalls
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 7; id_reg_wr = 1;
    edge_sample();
    @(negedge clk);
    id_rs1 = 7; id_uses_rs1 = 1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL lu_alu got %0b want 0", load_use_stall);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h300; id_rd = 4;
    id_reg_wr = 1; id_mem_wr = 1; id_alu_src = 1; id_alu_op = 4'd2;
    id_imm = 32'h10;
    ex_flush = 1;
    edge_sample();
    tests++;
    if ({ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, ex_alu_op}
        !== 9'b0) begin
      fails++; $display("FAIL fl_ctrl got %b%b%b%b%b %h want 00000 0",
        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src, ex_alu_op);
    end
    tests++;
    if ({ex_pc, ex_imm, ex_rd} !== 69'b0) begin
      fails++; $display("FAIL fl_data got pc=%h imm=%h rd=%0d want 0",
        ex_pc, ex_imm, ex_rd);
    end
    load_lw(5'd9);
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h310; id_rs1 = 9; id_uses_rs1 = 1;
    id_reg_wr = 1;
    ex_flush = 1;
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin
      fails++; $display("FAIL fs_stall got %0b want 1", load_use_stall);
    end
    edge_sample();
    tests++;
    if ({ex_valid, ex_reg_wr, ex_mem_rd} !== 3'b0) begin
      fails++; $display("FAIL fs_bubble got %b%b%b want 000",
        ex_valid, ex_reg_wr, ex_mem_rd);
    end
    @(negedge clk);
    ex_flush = 0;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL fs_stall_drop got %0b want 0", load_use_stall);
    end
    edge_sample();
    tests++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h310}) begin
      fails++; $display("FAIL fs_next got v=%0b pc=%h want 1 310",
        ex_valid, ex_pc);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_pc = 32'h400; id_rd = 3; id_reg_wr = 1;
    id_imm = 32'h55;
    edge_sample();
    tests++;
    if (ex_valid !== 1'b1) begin
      fails++; $display("FAIL ar_pre got %0b want 1", ex_valid);
    end
    #2;
    rst = 1;
    #1;
    tests++;
    if ({ex_valid, ex_pc, ex_imm, ex_reg_wr, ex_rd} !== 71'b0) begin
      fails++; $display("FAIL ar_clear got v=%0b pc=%h imm=%h wr=%0b rd=%0d want 0",
        ex_valid, ex_pc, ex_imm, ex_reg_wr, ex_rd);
    end
    @(negedge clk);
    rst = 0;
    id_pc = 32'h404; id_imm = 32'h66;
    edge_sample();
    tests++;
    if ({ex_valid, ex_pc, ex_imm, ex_reg_wr} !==
        {1'b1, 32'h404, 32'h66, 1'b1}) begin
      fails++; $display("FAIL ar_first got v=%0b pc=%h imm=%h wr=%0b want 1 404 66 1",
        ex_valid, ex_pc, ex_imm, ex_reg_wr);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
